fifo_rr_router: RTL and testbench
=================================

Name: fifo_rr_router

Overview:
- Downstream consumer of the four input FIFOs in the transaction layer.
- Pops words round-robin from up to 4 input FIFOs and routes each word by its 2 destination MSBs into one of 4 output FIFOs.
- Applies global back-pressure from the output FIFOs' almost-full flags.
- Keeps per-destination word counters and a sticky error state for verification.

Parameters:
- WORD_SIZE, 10, FIFO word width; bits [WORD_SIZE-1:WORD_SIZE-2] are the destination class.
- NUM_PORTS, 4, number of input and output FIFOs; fixed at 4, since the destination field is 2 bits.
- CNT_SIZE, 8, width of each per-destination word counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_empty  in  4  empty_flag of input FIFO i.
- in_error  in  4  error_flag of input FIFO i.
- in_data  in  4*WORD_SIZE  data_out of input FIFO i, slice [i*WORD_SIZE +: WORD_SIZE].
- out_almost_full  in  4  almost_full_flag of output FIFO j.
- out_full  in  4  full_flag of output FIFO j.
- pop  out  4  rd_en to input FIFO i; one-hot or zero.
- push  out  4  wr_en to output FIFO j; one-hot or zero.
- out_data  out  WORD_SIZE  data_in shared by all output FIFOs.
- state  out  3  current FSM state encoding.
- error  out  1  sticky error.
- word_count  out  4*CNT_SIZE  words pushed to output j, slice [j*CNT_SIZE +: CNT_SIZE].

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0; state = IDLE.
  - The round-robin pointer goes to 0; the pipeline valid bits and the mask are cleared.
  - An in-flight word is discarded, even when reset arrives mid-transfer.
- FSM states: IDLE=0, ACTIVE=1, PAUSE=2, ERROR=3. Transitions, evaluated each edge in priority order:
  - Any in_error, or the push-while-full condition below → ERROR, from every state.
  - |out_almost_full → PAUSE.
  - &in_empty → IDLE.
  - Otherwise → ACTIVE.
  - ERROR is left only by reset.
- Pop selection (combinational from registered state and inputs):
  - Pop only when state==ACTIVE and |out_almost_full==0.
  - Eligible inputs are ~in_empty & ~mask.
  - Grant the first eligible index at or after rr_ptr, wrapping 3→0.
  - pop = one-hot grant. On a pop, rr_ptr <= grant+1 (mod 4).
- Mask covers the one-cycle input-flag lag: mask <= one-hot of the last grant, or 0 when no pop occurred. A single non-empty input is therefore popped at most every other cycle.
- Datapath latency, pop in cycle t:
  - Memory read data from in_data[sel] is valid in cycle t+1.
  - It is registered at the end of t+1.
  - push[dest] = 1 and out_data = word in cycle t+2.
  - Fixed pop→push latency is 2 cycles; at most 2 words are in flight.
- Back-pressure:
  - A pause never cancels in-flight words; they complete their push.
  - Output FIFOs must use ALMOST_FULL_THRESHOLD ≤ DEPTH-2.
- Error condition: push[j] asserted while out_full[j]==1.
  - error <= 1 on the next edge; the word is still pushed.
  - In ERROR, pop is forced to 0; in-flight pushes drain.
- Counters:
  - word_count[j] increments on each push[j] and wraps at 2^CNT_SIZE.
  - Counters are cleared only by reset.
- Simultaneous events: one pop and one push in the same cycle is legal and expected during streaming.

Decomposition:
- Shared package: state encodings (IDLE, ACTIVE, PAUSE, ERROR) and the destination field position (DEST_MSB = WORD_SIZE-1, DEST_LSB = WORD_SIZE-2).
- One natural sub-module, rr_arbiter4: takes req[3:0] and ptr[1:0], returns a one-hot grant. It is purely combinational and reused by the FSM.

Test Plan:
- Single word: input 2 holds 0x2C5 (dest 2), all outputs empty. Expect pop=0100 at t, push=0100 with out_data=0x2C5 at t+2, word_count[2]=1.
- Round-robin: each input holds one word with dests 0,1,2,3. Expect pops in order 0,1,2,3 on consecutive cycles, pushes 0,1,2,3 two cycles later, every counter = 1.
- Single busy input: input 1 holds 4 words. Expect pop on alternating cycles only (mask), 4 pushes total, and a return to IDLE once in_empty=1111.
- Back-pressure: raise out_almost_full[3] while streaming. Expect pop=0 from the next cycle, state=PAUSE, ≤2 further pushes; after deassertion, ACTIVE resumes from rr_ptr.
- Errors:
  - Force out_full[0]=1 and push a dest-0 word. Expect error=1 one cycle later, state=ERROR, pop stays 0.
  - Separately, pulse in_error[3]. Expect ERROR.
- Async reset mid-transfer: assert reset between pop and push. Expect push, pop, counters and error all 0 immediately, state=IDLE, and no push after release.

Source files
------------

// File: rtl/fifo_rr_router_pkg.sv
// Shared definitions for the round-robin FIFO router: state encodings,
// default sizes, destination field position and a one-hot encoder helper.
package fifo_rr_router_pkg;

  localparam int DEF_WORD_SIZE = 10;
  localparam int DEF_CNT_SIZE  = 8;

  // Destination class lives in the two MSBs of a word of DEF_WORD_SIZE bits.
  localparam int DEST_MSB = DEF_WORD_SIZE - 1;
  localparam int DEST_LSB = DEF_WORD_SIZE - 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACTIVE = 3'd1;
  localparam logic [2:0] ST_PAUSE  = 3'd2;
  localparam logic [2:0] ST_ERROR  = 3'd3;

  // Index of the set bit of a one-hot (or zero) 4-bit vector.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/fifo_rr_router_arb.sv
// Four-way round-robin arbiter: grants the first requester at or after ptr,
// wrapping 3->0. Purely combinational.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) grant = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/fifo_rr_router.sv
// Round-robin router: pops words from four input FIFOs, routes each by its
// destination class into one of four output FIFOs two cycles later, applies
// back-pressure from almost-full flags and tracks per-destination counts.
//
// Handshake: pop[i] is a one-cycle read strobe to input FIFO i whose data is
// presented on in_data one cycle later; push[j] is a one-cycle write strobe to
// output FIFO j qualified with out_data in the same cycle. Neither side stalls
// a strobe once issued.
module fifo_rr_router
  import fifo_rr_router_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_PORTS = 4,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_empty,
  input  logic [NUM_PORTS-1:0]            in_error,
  input  logic [NUM_PORTS*WORD_SIZE-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]            out_almost_full,
  input  logic [NUM_PORTS-1:0]            out_full,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [NUM_PORTS-1:0]            push,
  output logic [WORD_SIZE-1:0]            out_data,
  output logic [2:0]                      state,
  output logic                            error,
  output logic [NUM_PORTS*CNT_SIZE-1:0]   word_count
);

  // Keeps the destination field at the top two bits for any word width.
  localparam int DEST_SHIFT = WORD_SIZE - DEF_WORD_SIZE;

  logic [2:0]           state_next;
  logic [1:0]           rr_ptr;
  logic [3:0]           mask;
  logic [3:0]           req;
  logic [3:0]           grant;
  logic [1:0]           grant_idx;
  logic                 pop_en;
  logic                 s1_valid;
  logic [1:0]           s1_sel;
  logic                 s2_valid;
  logic [WORD_SIZE-1:0] s2_word;
  logic [WORD_SIZE-1:0] rd_word;
  logic [1:0]           s2_dest;
  logic                 err_cond;
  logic [CNT_SIZE-1:0]  cnt [4];

  rr_arbiter4 u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Pop request: only when active and no output is near full; the mask hides
  // an input popped last cycle whose empty flag has not caught up yet.
  always_comb begin
    pop_en    = (state == ST_ACTIVE) && !(|out_almost_full);
    req       = pop_en ? (~in_empty & ~mask) : 4'b0000;
    grant_idx = onehot_to_idx(grant);
    pop       = grant;
  end

  // Output side: word read last cycle is in s2 and is pushed to its class.
  always_comb begin
    rd_word  = in_data[int'(s1_sel) * WORD_SIZE +: WORD_SIZE];
    s2_dest  = s2_word[DEST_MSB + DEST_SHIFT : DEST_LSB + DEST_SHIFT];
    push     = s2_valid ? (4'b0001 << s2_dest) : 4'b0000;
    out_data = s2_word;
    err_cond = (|in_error) || (|(push & out_full));
    error    = (state == ST_ERROR);
  end

  // Next-state selection in priority order; ERROR only exits via reset.
  always_comb begin
    state_next = ST_ACTIVE;
    if (state == ST_ERROR || err_cond) state_next = ST_ERROR;
    else if (|out_almost_full)         state_next = ST_PAUSE;
    else if (&in_empty)                state_next = ST_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Arbitration bookkeeping and the two-stage pop-to-push pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      mask     <= '0;
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s2_valid <= 1'b0;
      s2_word  <= '0;
    end else begin
      if (|grant) rr_ptr <= grant_idx + 2'd1;
      mask     <= grant;
      s1_valid <= |grant;
      s1_sel   <= grant_idx;
      s2_valid <= s1_valid;
      if (s1_valid) s2_word <= rd_word;
    end
  end

  // Per-destination push counters, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++)
        if (push[j]) cnt[j] <= cnt[j] + 1'b1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    word_count = '0;
    for (int j = 0; j < 4; j++) word_count[j*CNT_SIZE +: CNT_SIZE] = cnt[j];
  end

endmodule

// File: tb/tb_fifo_rr_router.sv
// Bench for fifo_rr_router: queue-based input FIFO models, a latency
// scoreboard keyed on observed pops, counters predicted from loaded words,
// directed scenarios and a randomized streaming phase.
module tb_fifo_rr_router;
  import fifo_rr_router_pkg::*;

  localparam int W = 10;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     in_empty, in_error, out_almost_full, out_full, pop, push;
  logic [4*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic [2:0]     state;
  logic           error;
  logic [4*C-1:0] word_count;

  fifo_rr_router dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty        (in_empty),
    .in_error        (in_error),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .pop             (pop),
    .push            (push),
    .out_data        (out_data),
    .state           (state),
    .error           (error),
    .word_count      (word_count)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Input FIFO models (read data appears the cycle after pop, empty lags)
  logic [W-1:0] in_q [4][$];
  logic [W-1:0] dout [4];
  logic [3:0]   empty_r;

  assign in_empty = empty_r;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = dout[i];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      empty_r <= '1;
      for (int i = 0; i < 4; i++) dout[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        empty_r[i] <= (in_q[i].size() == 0);
        if (pop[i] && in_q[i].size() > 0) begin
          dout[i] <= in_q[i][0];
          void'(in_q[i].pop_front());
        end
      end
    end
  end

  // Scoreboard and monitor state
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  int           pop_log [$];
  int           pop_cyc [$];
  logic [7:0]   cnt_model [4];
  int           cyc = 0;
  int           last_pop = 0;
  int           push_seen = 0;
  logic         err_next = 1'b0;
  logic         err_state = 1'b0;
  logic [3:0]   prev_pop = '0;

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check_val("push_dest", 32'(push), 32'(4'b0001 << exp_q[0][DEST_MSB:DEST_LSB]));
        check_val("out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        push_seen++;
      end else begin
        check_val("no_push", 32'(push), 0);
      end
      if (err_next) begin
        check_val("err_flag", 32'(error), 1);
        check_val("err_state", 32'(state), 32'(ST_ERROR));
        err_state = 1'b1;
      end
      if (err_state) check_val("err_pop", 32'(pop), 0);
      err_next = err_next | (|in_error) | (|(push & out_full));
      if (|out_almost_full) check_val("bp_pop", 32'(pop), 0);
      if (|pop) begin
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (pop[i]) idx = i;
        check_val("pop_onehot", $countones(pop), 1);
        check_val("pop_mask", 32'(pop & prev_pop), 0);
        check_val("pop_nonempty", 32'(in_q[idx].size() > 0), 1);
        if (in_q[idx].size() > 0) begin
          exp_q.push_back(in_q[idx][0]);
          due_q.push_back(cyc + 2);
        end
        pop_log.push_back(idx);
        pop_cyc.push_back(cyc);
        last_pop = idx;
      end
      prev_pop = pop;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_error = '0;
    out_full = '0;
    out_almost_full = '0;
    for (int i = 0; i < 4; i++) in_q[i].delete();
    exp_q.delete();
    due_q.delete();
    pop_log.delete();
    pop_cyc.delete();
    for (int j = 0; j < 4; j++) cnt_model[j] = '0;
    err_next = 1'b0;
    err_state = 1'b0;
    prev_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int i, input logic [W-1:0] w);
    in_q[i].push_back(w);
    cnt_model[w[DEST_MSB:DEST_LSB]]++;
  endtask

  task automatic wait_drain(input int max);
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < max) begin
      busy = (due_q.size() > 0);
      for (int i = 0; i < 4; i++) if (in_q[i].size() > 0) busy = 1'b1;
      if (busy) begin
        tick(1);
        k++;
      end
    end
    check_val("drain_done", 32'(k < max), 1);
    tick(4);
  endtask

  task automatic check_counts(input string tag);
    for (int j = 0; j < 4; j++)
      check_val($sformatf("%s_cnt%0d", tag, j), 32'(word_count[j*C +: C]), 32'(cnt_model[j]));
  endtask

  // Stimulus
  initial begin
    int lp, ps, k;
    reset = 1'b1;
    in_error = '0;
    out_full = '0;
    out_almost_full = '0;
    #2;
    check_val("rst_pop", 32'(pop), 0);
    check_val("rst_push", 32'(push), 0);
    check_val("rst_state", 32'(state), 32'(ST_IDLE));
    check_val("rst_error", 32'(error), 0);
    check_val("rst_count", word_count, 0);
    check_val("rst_data", 32'(out_data), 0);
    do_reset();

    // Single word on input 2
    load(2, 10'h2C5);
    wait_drain(50);
    check_val("t1_npop", pop_log.size(), 1);
    check_val("t1_idx", pop_log[0], 2);
    check_counts("t1");
    check_val("t1_idle", 32'(state), 32'(ST_IDLE));

    // One word per input, all destinations
    do_reset();
    load(0, 10'h0AA);
    load(1, 10'h155);
    load(2, 10'h2AA);
    load(3, 10'h3C3);
    wait_drain(50);
    check_val("t2_npop", pop_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_order", pop_log[i], i);
      check_val("t2_consec", pop_cyc[i] - pop_cyc[0], i);
    end
    check_counts("t2");

    // Single busy input
    do_reset();
    for (int i = 0; i < 4; i++) load(1, W'($urandom_range(0, 1023)));
    wait_drain(80);
    check_val("t3_npop", pop_log.size(), 4);
    for (int i = 1; i < 4; i++) begin
      check_val("t3_idx", pop_log[i], 1);
      check_val("t3_gap", 32'((pop_cyc[i] - pop_cyc[i-1]) >= 2), 1);
    end
    check_counts("t3");
    check_val("t3_idle", 32'(state), 32'(ST_IDLE));

    // Back-pressure while streaming
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 6; n++) load(i, W'($urandom_range(0, 1023)));
    tick(6);
    lp = last_pop;
    ps = push_seen;
    out_almost_full = 4'b1000;
    tick(1);
    check_val("t4_pause", 32'(state), 32'(ST_PAUSE));
    tick(5);
    check_val("t4_inflight", 32'((push_seen - ps) <= 2), 1);
    pop_log.delete();
    pop_cyc.delete();
    out_almost_full = '0;
    k = 0;
    while (pop_log.size() == 0 && k < 10) begin
      tick(1);
      k++;
    end
    check_val("t4_resume_idx", pop_log[0], (lp + 1) % 4);
    check_val("t4_resume_state", 32'(state), 32'(ST_ACTIVE));
    wait_drain(200);
    check_counts("t4");

    // Randomized streaming with random back-pressure
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int m = 0; m < n; m++) load(i, W'($urandom_range(0, 1023)));
      end
      for (int c = 0; c < 40; c++) begin
        out_almost_full = ($urandom_range(0, 4) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        tick(1);
      end
      out_almost_full = '0;
      wait_drain(300);
      check_counts("t5");
    end

    // Push into a full output FIFO
    do_reset();
    out_full = 4'b0001;
    load(0, 10'h055);
    tick(10);
    check_val("t6_error", 32'(error), 1);
    check_val("t6_state", 32'(state), 32'(ST_ERROR));
    load(1, 10'h1F0);
    tick(6);
    check_val("t6_no_pop", in_q[1].size(), 1);
    check_val("t6_cnt0", 32'(word_count[0 +: C]), 1);

    // Input error pulse
    do_reset();
    in_error = 4'b1000;
    tick(1);
    in_error = '0;
    tick(2);
    check_val("t7_state", 32'(state), 32'(ST_ERROR));
    check_val("t7_error", 32'(error), 1);

    // Asynchronous reset with a word in flight
    do_reset();
    load(0, 10'h3A5);
    k = 0;
    while (pop_log.size() == 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_val("t8_popped", pop_log.size(), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("t8_push", 32'(push), 0);
    check_val("t8_pop", 32'(pop), 0);
    check_val("t8_count", word_count, 0);
    check_val("t8_error", 32'(error), 0);
    check_val("t8_state", 32'(state), 32'(ST_IDLE));
    do_reset();
    ps = push_seen;
    tick(8);
    check_val("t8_no_push_after", push_seen - ps, 0);
    check_val("t8_count_after", word_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
